// File: rtl/mitll_sfq_pkg.sv
// mitll_sfq_pkg: shared types and helpers for the clocked SFQ cell models
package mitll_sfq_pkg;
    localparam int PULSE_CNT_W = 16;
    typedef enum logic [1:0] {STARTUP, RUN, ERROR} state_t;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/mitll_merget_sync_if.sv
// mitll_merget_sync_if: toggle-encoded pulse pins and status of the merger cell
interface mitll_merget_sync_if;
    import mitll_sfq_pkg::*;
    logic                   in1;
    logic                   in2;
    logic                   out;
    logic                   err;
    logic                   viol;
    logic [PULSE_CNT_W-1:0] pulse_count;
    modport master (output in1, in2, input out, err, viol, pulse_count);
    modport slave  (input in1, in2, output out, err, viol, pulse_count);
endinterface

// File: rtl/mitll_pulse_delay_line.sv
// mitll_pulse_delay_line: toggle-request shift register; a request inserted at offset d reaches the tail d cycles later
module mitll_pulse_delay_line #(
    parameter int DEPTH = 3,
    parameter int OW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_ins,
    input  logic [OW-1:0] i_off,
    output logic          o_tail
);
    logic [DEPTH-1:0] r_sr;
    logic [DEPTH-1:0] w_ins;

    assign w_ins  = i_ins ? (DEPTH'(1) << (i_off - OW'(1))) : '0;
    assign o_tail = r_sr[0];

    // Requests move one slot toward the tail per cycle; clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst || i_clr) r_sr <= '0;
        else              r_sr <= (r_sr >> 1) | w_ins;
    end
endmodule

// File: rtl/mitll_merget_sync.sv
// mitll_merget_sync: cycle-based RSFQ merger with per-input delay, critical-timing window and error freeze
module mitll_merget_sync
    import mitll_sfq_pkg::*;
#(
    parameter int DELAY_IN1     = 3,
    parameter int DELAY_IN2     = 2,
    parameter int CT_CYCLES     = 2,
    parameter int STEADY_CYCLES = 4,
    parameter int BIAS_OK       = 1
) (
    input logic                clk,
    input logic                rst,
    mitll_merget_sync_if.slave bus
);
    localparam int DEPTH = max_int(DELAY_IN1, DELAY_IN2);
    localparam int OW    = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(CT_CYCLES + 1);
    localparam int DDIFF = (DELAY_IN1 > DELAY_IN2) ? DELAY_IN1 - DELAY_IN2 : DELAY_IN2 - DELAY_IN1;

    // Two accepted requests must never reach the tail in the same cycle.
    if (DELAY_IN1 < 1 || DELAY_IN2 < 1 || CT_CYCLES < 1 || CT_CYCLES <= DDIFF) begin : g_param_chk
        $error("mitll_merget_sync: illegal DELAY_IN1/DELAY_IN2/CT_CYCLES combination");
    end

    state_t                 r_state;
    state_t                 w_state_n;
    logic                   r_in1_q;
    logic                   r_in2_q;
    logic                   w_e1;
    logic                   w_e2;
    logic                   w_viol;
    logic                   w_accept;
    logic                   w_tail;
    logic                   w_fire;
    logic [OW-1:0]          w_off;
    logic [CW-1:0]          r_ct;
    logic [31:0]            r_settle;
    logic                   r_out;
    logic                   r_err;
    logic                   r_viol;
    logic [PULSE_CNT_W-1:0] r_cnt;

    assign w_e1   = bus.in1 ^ r_in1_q;
    assign w_e2   = bus.in2 ^ r_in2_q;
    assign w_fire = w_tail && (r_state == RUN) && !w_viol;

    assign bus.out         = r_out;
    assign bus.err         = r_err;
    assign bus.viol        = r_viol;
    assign bus.pulse_count = r_cnt;

    // Input history follows the pins every cycle, reset included, so a held level never looks like an edge.
    always_ff @(posedge clk) begin
        r_in1_q <= bus.in1;
        r_in2_q <= bus.in2;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= STARTUP;
        else     r_state <= w_state_n;
    end

    // Next state plus edge acceptance; an edge inside the window or a coincident pair is a violation.
    always_comb begin
        w_state_n = r_state;
        w_viol    = 1'b0;
        w_accept  = 1'b0;
        w_off     = w_e1 ? OW'(DELAY_IN1) : OW'(DELAY_IN2);
        case (r_state)
            STARTUP: begin
                if (BIAS_OK == 0)                                   w_state_n = ERROR;
                else if (r_settle + 32'd1 >= 32'(STEADY_CYCLES))    w_state_n = RUN;
            end
            RUN: begin
                if (w_e1 || w_e2) begin
                    w_viol    = (r_ct != '0) || (w_e1 && w_e2);
                    w_accept  = !w_viol;
                    w_state_n = w_viol ? ERROR : RUN;
                end
            end
            default: w_state_n = ERROR;
        endcase
    end

    // Settling counter runs only during startup; the timing window reloads on every accepted edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle <= '0;
            r_ct     <= '0;
        end else begin
            r_settle <= (r_state == STARTUP) ? r_settle + 32'd1 : r_settle;
            r_ct     <= w_accept ? CW'(CT_CYCLES) : ((r_ct != '0) ? r_ct - CW'(1) : r_ct);
        end
    end

    // Merged output toggles when a request leaves the line; error is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= 1'b0;
            r_cnt  <= '0;
            r_viol <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_fire) begin
                r_out <= ~r_out;
                r_cnt <= r_cnt + PULSE_CNT_W'(1);
            end
            r_viol <= w_viol;
            r_err  <= (w_state_n == ERROR);
        end
    end

    mitll_pulse_delay_line #(.DEPTH(DEPTH), .OW(OW)) u_dl (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_viol || (r_state != RUN)),
        .i_ins  (w_accept),
        .i_off  (w_off),
        .o_tail (w_tail)
    );
endmodule

// File: tb/tb_mitll_merget_sync.sv
// tb_mitll_merget_sync: directed scoreboard bench for the merger, plus a bad-bias instance
module tb_mitll_merget_sync;
    import mitll_sfq_pkg::*;

    typedef struct {
        bit viol;
        int cyc;
        int cnt;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   b_viol_seen = 1'b0;
    logic prev_out = 1'b0;
    ev_t  q[$];

    mitll_merget_sync_if bus ();
    mitll_merget_sync_if bus_b ();

    mitll_merget_sync dut (.clk(clk), .rst(rst), .bus(bus));
    mitll_merget_sync #(.BIAS_OK(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_b.in1 = bus.in1;
    assign bus_b.in2 = bus.in2;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_ev(input bit v);
        ev_t e;
        if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_%s: got an event at cycle %0d, required none", v ? "viol" : "toggle", cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", int'(v), int'(e.viol));
            chk("event_cycle", cyc, e.cyc);
            chk("event_count", int'(bus.pulse_count), e.cnt);
            if (v) chk("event_err", int'(bus.err), 1);
        end
    endtask

    always @(negedge clk) begin
        if (cyc != 0 && !rst) begin
            if (bus.out !== prev_out) expect_ev(1'b0);
            if (bus.viol) expect_ev(1'b1);
        end
        if (bus_b.viol) b_viol_seen = 1'b1;
        prev_out = bus.out;
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic at(input int n);
        while (cyc != n) @(negedge clk);
    endtask

    task automatic end_chk(input string t, input int o, input int c, input int e);
        chk({t, "_out"}, int'(bus.out), o);
        chk({t, "_count"}, int'(bus.pulse_count), c);
        chk({t, "_err"}, int'(bus.err), e);
        chk({t, "_queue_left"}, q.size(), 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in1 = 1'b0;
        bus.in2 = 1'b0;
        // single in1 pulse, plus reset values and bad-bias entry
        do_reset();
        chk("rst_out", int'(bus.out), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_viol", int'(bus.viol), 0);
        chk("rst_count", int'(bus.pulse_count), 0);
        at(1);
        chk("bias_err_edge1", int'(bus_b.err), 1);
        at(9);  bus.in1 = ~bus.in1; q.push_back('{1'b0, 13, 1});
        at(20); end_chk("t1", 1, 1, 0);
        // edge during startup is ignored
        do_reset();
        at(1);  bus.in1 = ~bus.in1;
        at(20); end_chk("t5", 0, 0, 0);
        // in2 then in1 outside the window
        do_reset();
        at(9);  bus.in2 = ~bus.in2; q.push_back('{1'b0, 12, 1});
        at(12); bus.in1 = ~bus.in1; q.push_back('{1'b0, 16, 2});
        at(20); end_chk("t2", 0, 2, 0);
        // in2 inside the window of in1
        do_reset();
        at(9);  bus.in1 = ~bus.in1;
        at(11); bus.in2 = ~bus.in2; q.push_back('{1'b1, 12, 0});
        at(20); end_chk("t3", 0, 0, 1);
        chk("t3_viol_low", int'(bus.viol), 0);
        // coincident edges, then an edge while in error
        do_reset();
        at(9);  bus.in1 = ~bus.in1; bus.in2 = ~bus.in2; q.push_back('{1'b1, 10, 0});
        at(14); bus.in1 = ~bus.in1;
        at(20); end_chk("t4", 0, 0, 1);
        // reset with a request in flight
        do_reset();
        at(9);  bus.in1 = ~bus.in1;
        at(10); do_reset();
        at(20); end_chk("t6", 0, 0, 0);
        // bad-bias instance stayed frozen throughout
        chk("bias_err", int'(bus_b.err), 1);
        chk("bias_out", int'(bus_b.out), 0);
        chk("bias_count", int'(bus_b.pulse_count), 0);
        chk("bias_viol_seen", int'(b_viol_seen), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
